// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: widths, ALU control codes
// and the sequencer state encoding.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CTRL_WIDTH = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_request_arbiter_if.sv
// Bundle of the two request channels, the ALU drive/return path and the
// response channel. The arbiter uses the slave view, its environment the master view.
interface alu_request_arbiter_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int CTRL_WIDTH = alu_pkg::CTRL_WIDTH
);
    // Handshake rule on every channel: a transfer happens in a cycle where
    // valid and ready are both high; the sender holds its payload stable while
    // valid && !ready, and ready never appears except for a transfer.
    logic                  req0_valid;
    logic                  req0_ready;
    logic [CTRL_WIDTH-1:0] req0_control;
    logic [DATA_WIDTH-1:0] req0_operand0;
    logic [DATA_WIDTH-1:0] req0_operand1;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [CTRL_WIDTH-1:0] req1_control;
    logic [DATA_WIDTH-1:0] req1_operand0;
    logic [DATA_WIDTH-1:0] req1_operand1;

    logic [CTRL_WIDTH-1:0] alu_control;
    logic [DATA_WIDTH-1:0] alu_operand0;
    logic [DATA_WIDTH-1:0] alu_operand1;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_overflow;
    logic                  alu_zero;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_overflow;
    logic                  rsp_zero;

    modport slave (
        input  req0_valid, req0_control, req0_operand0, req0_operand1,
        input  req1_valid, req1_control, req1_operand0, req1_operand1,
        input  alu_result, alu_overflow, alu_zero, rsp_ready,
        output req0_ready, req1_ready,
        output alu_control, alu_operand0, alu_operand1,
        output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero
    );

    modport master (
        output req0_valid, req0_control, req0_operand0, req0_operand1,
        output req1_valid, req1_control, req1_operand0, req1_operand1,
        output alu_result, alu_overflow, alu_zero, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_control, alu_operand0, alu_operand1,
        input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant, registered 1-bit pointer
// that flips to the other requester after every grant.
module rr_arbiter_2 (
    input  logic clock,
    input  logic reset_n,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant0,
    output logic grant1,
    output logic pointer
);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            // Pointer only breaks ties; a lone requester always wins.
            if (valid0 && valid1) begin
                grant0 = !pointer;
                grant1 = pointer;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pointer <= 1'b0;
        end else if (grant0) begin
            pointer <= 1'b1;
        end else if (grant1) begin
            pointer <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one external ALU between two requesters: accept, execute for one
// cycle, then hold a tagged response until the consumer takes it.
module alu_request_arbiter
    import alu_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    alu_request_arbiter_if.slave   bus,
    output state_t                 state,
    output logic                   pointer
);

    logic grant0;
    logic grant1;
    logic take;
    logic accept_window;
    logic op_id;

    // New work is taken when idle, or in the same cycle the pending response
    // is consumed. Gating with reset_n keeps both readies low while in reset.
    assign accept_window = reset_n &&
                           ((state == IDLE) || ((state == RESP) && bus.rsp_ready));

    rr_arbiter_2 u_arbiter (
        .clock   (clock),
        .reset_n (reset_n),
        .valid0  (bus.req0_valid),
        .valid1  (bus.req1_valid),
        .enable  (accept_window),
        .grant0  (grant0),
        .grant1  (grant1),
        .pointer (pointer)
    );

    assign take           = grant0 || grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            op_id            <= 1'b0;
            bus.alu_control  <= '0;
            bus.alu_operand0 <= '0;
            bus.alu_operand1 <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_id       <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_zero     <= 1'b0;
        end else begin
            // The op registers drive the ALU directly, so they keep their
            // last value outside EXEC.
            if (take) begin
                op_id            <= grant1;
                bus.alu_control  <= grant1 ? bus.req1_control  : bus.req0_control;
                bus.alu_operand0 <= grant1 ? bus.req1_operand0 : bus.req0_operand0;
                bus.alu_operand1 <= grant1 ? bus.req1_operand1 : bus.req0_operand1;
            end
            case (state)
                IDLE: begin
                    if (take) state <= EXEC;
                end
                EXEC: begin
                    bus.rsp_id       <= op_id;
                    bus.rsp_result   <= bus.alu_result;
                    bus.rsp_overflow <= bus.alu_overflow;
                    bus.rsp_zero     <= bus.alu_zero;
                    bus.rsp_valid    <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= take ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed and randomized bench for alu_request_arbiter; a cycle-level model of
// accept/response timing and round-robin choice predicts every output.
module tb_alu_request_arbiter;
    import alu_pkg::*;

    localparam int RW = 35;  // {id, overflow, zero, result}

    logic   clock = 1'b0;
    logic   reset_n = 1'b0;
    state_t dbg_state;
    logic   dbg_pointer;

    always #5 clock = ~clock;

    alu_request_arbiter_if bus ();

    alu_request_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .state   (dbg_state),
        .pointer (dbg_pointer)
    );

    function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (c)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            ALU_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            default: r = a ^ 32'hA5A5_5A5A;
        endcase
        return {v, r};
    endfunction

    // Combinational ALU owned by the bench (the parent of the arbiter).
    logic [32:0] alu_out;
    assign alu_out          = alu_fn(bus.alu_control, bus.alu_operand0, bus.alu_operand1);
    assign bus.alu_result   = alu_out[31:0];
    assign bus.alu_overflow = alu_out[32];
    assign bus.alu_zero     = (alu_out[31:0] == 32'd0);

    function automatic logic [RW-1:0] expect_rsp(input logic id, input logic [3:0] c,
                                                 input logic [31:0] a, input logic [31:0] b);
        logic [32:0] o;
        o = alu_fn(c, a, b);
        return {id, o[32], (o[31:0] == 32'd0), o[31:0]};
    endfunction

    int pass_count = 0;
    int fail_count = 0;
    int total_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: at most one operation outstanding, its response visible
    // from two cycles after acceptance until consumed.
    logic [RW-1:0] exp_q[$];
    int            cyc = 0;
    int            op_cycle = 0;
    bit            ptr = 1'b0;
    logic [3:0]    m_ctrl = '0;
    logic [31:0]   m_a = '0;
    logic [31:0]   m_b = '0;

    bit            want[2];
    logic [3:0]    rc[2];
    logic [31:0]   ra[2];
    logic [31:0]   rb[2];

    task automatic model_clear();
        exp_q.delete();
        ptr    = 1'b0;
        m_ctrl = '0;
        m_a    = '0;
        m_b    = '0;
    endtask

    task automatic apply_reqs();
        bus.req0_valid    = want[0];
        bus.req0_control  = rc[0];
        bus.req0_operand0 = ra[0];
        bus.req0_operand1 = rb[0];
        bus.req1_valid    = want[1];
        bus.req1_control  = rc[1];
        bus.req1_operand0 = ra[1];
        bus.req1_operand1 = rb[1];
    endtask

    task automatic set_req(input int n, input bit v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        want[n] = v;
        rc[n]   = c;
        ra[n]   = a;
        rb[n]   = b;
        apply_reqs();
    endtask

    task automatic rand_req(input int n);
        logic [31:0] a;
        a = $urandom;
        set_req(n, 1'b1, 4'($urandom_range(0, 15)), a,
                ($urandom_range(0, 3) == 0) ? a : 32'($urandom));
    endtask

    task automatic step(output logic [1:0] rdy, output bit took, output logic [RW-1:0] seen);
        bit vis, can;
        int winner;
        logic [3:0] c;
        logic [31:0] a, b;
        @(negedge clock);
        cyc++;
        vis  = (exp_q.size() != 0) && (cyc >= op_cycle + 2);
        took = vis && (bus.rsp_ready === 1'b1);
        can  = (exp_q.size() == 0) || took;
        winner = -1;
        if (can) begin
            if (bus.req0_valid && bus.req1_valid) winner = ptr ? 1 : 0;
            else if (bus.req0_valid) winner = 0;
            else if (bus.req1_valid) winner = 1;
        end
        rdy  = {bus.req1_ready, bus.req0_ready};
        seen = {bus.rsp_id, bus.rsp_overflow, bus.rsp_zero, bus.rsp_result};
        check("req0_ready", bus.req0_ready, (winner == 0));
        check("req1_ready", bus.req1_ready, (winner == 1));
        check("rsp_valid", bus.rsp_valid, vis);
        check("alu_control", bus.alu_control, m_ctrl);
        check("alu_operand0", bus.alu_operand0, m_a);
        check("alu_operand1", bus.alu_operand1, m_b);
        if (vis) check("rsp_fields", seen, exp_q[0]);
        if (took) void'(exp_q.pop_front());
        if (winner >= 0) begin
            if (winner == 1) begin c = bus.req1_control; a = bus.req1_operand0; b = bus.req1_operand1; end
            else begin c = bus.req0_control; a = bus.req0_operand0; b = bus.req0_operand1; end
            exp_q.push_back(expect_rsp(winner[0], c, a, b));
            op_cycle = cyc;
            ptr      = (winner == 0);
            m_ctrl   = c;
            m_a      = a;
            m_b      = b;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        reset_n = 1'b0;
        @(negedge clock);
        check("rst_req0_ready", bus.req0_ready, 1'b0);
        check("rst_req1_ready", bus.req1_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_id", bus.rsp_id, 1'b0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_rsp_flags", {bus.rsp_overflow, bus.rsp_zero}, 2'b00);
        check("rst_alu_ops", {bus.alu_control, bus.alu_operand0, bus.alu_operand1}, 68'd0);
        check("rst_pointer", dbg_pointer, 1'b0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [1:0]    rdy;
        bit            took;
        logic [RW-1:0] seen;
        logic [RW-1:0] held;
        int            grants;
        int            budget;

        bus.rsp_ready = 1'b1;
        do_reset();

        // Single request: ADD 5+7 from requester 0.
        set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        step(rdy, took, seen);
        check("t1_accept_ready", rdy, 2'b01);
        set_req(0, 1'b0, '0, '0, '0);
        step(rdy, took, seen);
        step(rdy, took, seen);
        check("t1_rsp_id", seen[34], 1'b0);
        check("t1_rsp_result", seen[31:0], 32'd12);
        check("t1_rsp_flags", seen[33:32], 2'b00);
        step(rdy, took, seen);

        // Tie after reset: requester 0 first, requester 1 taken in its RESP cycle.
        do_reset();
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, ALU_SUB, 32'd10, 32'd3);
        step(rdy, took, seen);
        check("t2_first_grant", rdy, 2'b01);
        set_req(0, 1'b0, '0, '0, '0);
        step(rdy, took, seen);
        step(rdy, took, seen);
        check("t2_second_in_resp", rdy, 2'b10);
        check("t2_rsp0", {seen[34], seen[31:0]}, {1'b0, 32'd2});
        set_req(1, 1'b0, '0, '0, '0);
        step(rdy, took, seen);
        step(rdy, took, seen);
        check("t2_rsp1", {seen[34], seen[31:0]}, {1'b1, 32'd7});
        step(rdy, took, seen);

        // Fairness: requester 0 always valid, requester 1 joins after first grant.
        do_reset();
        rand_req(0);
        grants = 0;
        budget = 0;
        while (grants < 6 && budget < 60) begin
            step(rdy, took, seen);
            budget++;
            if (rdy != 2'b00) begin
                check("t3_grant_order", rdy, (grants % 2 == 0) ? 2'b01 : 2'b10);
                grants++;
                if (rdy[0]) rand_req(0);
                if (rdy[1]) rand_req(1);
                if (grants == 1) rand_req(1);
            end
        end
        check("t3_grant_count", grants, 6);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) step(rdy, took, seen);

        // Backpressure for 4 cycles in RESP with requester 1 waiting.
        set_req(0, 1'b1, ALU_XOR, 32'hF0F0_1234, 32'h0FF0_4321);
        held = expect_rsp(1'b0, ALU_XOR, 32'hF0F0_1234, 32'h0FF0_4321);
        step(rdy, took, seen);
        set_req(0, 1'b0, '0, '0, '0);
        step(rdy, took, seen);
        bus.rsp_ready = 1'b0;
        set_req(1, 1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(rdy, took, seen);
            check("t4_no_ready", rdy, 2'b00);
            check("t4_rsp_held", seen, held);
        end
        bus.rsp_ready = 1'b1;
        step(rdy, took, seen);
        check("t4_release_accept", rdy, 2'b10);
        set_req(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) step(rdy, took, seen);

        // Zero flag: requester 1 SUB 9-9.
        set_req(1, 1'b1, ALU_SUB, 32'd9, 32'd9);
        step(rdy, took, seen);
        set_req(1, 1'b0, '0, '0, '0);
        step(rdy, took, seen);
        step(rdy, took, seen);
        check("t5_rsp_id", seen[34], 1'b1);
        check("t5_rsp_zero", seen[32], 1'b1);
        check("t5_rsp_result", seen[31:0], 32'd0);
        step(rdy, took, seen);

        // Reset pulse while an operation is in EXEC.
        do_reset();
        set_req(0, 1'b1, ALU_ADD, 32'd3, 32'd4);
        step(rdy, took, seen);
        set_req(0, 1'b0, '0, '0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rsp_valid_async", bus.rsp_valid, 1'b0);
        check("t6_state_async", dbg_state, IDLE);
        check("t6_pointer_async", dbg_pointer, 1'b0);
        check("t6_alu_ctrl_async", bus.alu_control, 4'd0);
        model_clear();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(rdy, took, seen);
        set_req(0, 1'b1, ALU_OR, 32'h1, 32'h2);
        set_req(1, 1'b1, ALU_AND, 32'h3, 32'h6);
        step(rdy, took, seen);
        check("t6_tie_after_reset", rdy, 2'b01);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) step(rdy, took, seen);

        // Randomized traffic with random backpressure and occasional withdrawals.
        for (int i = 0; i < 400; i++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 2; n++) begin
                if (!want[n]) begin
                    if ($urandom_range(0, 2) == 0) rand_req(n);
                end else if ($urandom_range(0, 15) == 0) begin
                    set_req(n, 1'b0, rc[n], ra[n], rb[n]);
                end
            end
            step(rdy, took, seen);
            if (rdy[0]) set_req(0, 1'b0, rc[0], ra[0], rb[0]);
            if (rdy[1]) set_req(1, 1'b0, rc[1], ra[1], rb[1]);
        end
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) step(rdy, took, seen);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
